// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared encodings for the cache-to-AXI arbiter.
// Provides the one-hot read/write FSM states, the read owner enum,
// the default line offset and the AXI beat-size constants.
package cache_axi_pkg;

    localparam int LINE_OFF_DEF = 6;

    localparam logic [2:0] BYTE = 3'b000;
    localparam logic [2:0] HALF = 3'b001;
    localparam logic [2:0] WORD = 3'b010;

    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_ADDR = 3'b010,
        R_DATA = 3'b100
    } rd_state_t;

    typedef enum logic [3:0] {
        W_IDLE = 4'b0001,
        W_ADDR = 4'b0010,
        W_DATA = 4'b0100,
        W_RESP = 4'b1000
    } wr_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/axi_wr_seq.sv
// axi_wr_seq: sequences one D-cache write-back through the AXI AW, W and B phases.
// Ports: clk/rstn (sync, active-low); D-cache side req/addr/length/size/data/strb in,
// rdy/next/finish out; busy and the latched awaddr feed the read hazard check;
// AXI AW/W/B channel signals toward the slave.
module axi_wr_seq
    import cache_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        length,
    input  logic [2:0]        size,
    output logic              rdy,
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        strb,
    output logic              next,
    output logic              finish,
    output logic              busy,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready
);

    wr_state_t   state;
    logic [7:0]  beat_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= W_IDLE;
            awaddr   <= '0;
            awlen    <= '0;
            awsize   <= '0;
            beat_cnt <= '0;
            finish   <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                W_IDLE: if (req) begin
                    awaddr   <= addr;
                    awlen    <= length;
                    awsize   <= size;
                    beat_cnt <= length;
                    state    <= W_ADDR;
                end
                W_ADDR: if (awready) state <= W_DATA;
                W_DATA: if (wready) begin
                    beat_cnt <= beat_cnt - 8'd1;
                    if (beat_cnt == 8'd0) state <= W_RESP;
                end
                W_RESP: if (bvalid) begin
                    // finish is registered, so it lands the cycle after the B handshake
                    finish <= 1'b1;
                    state  <= W_IDLE;
                end
                default: state <= W_IDLE;
            endcase
        end
    end

    assign busy    = state != W_IDLE;
    assign awvalid = state == W_ADDR;
    assign rdy     = awvalid & awready;
    assign wvalid  = state == W_DATA;
    assign wlast   = wvalid & (beat_cnt == 8'd0);
    assign next    = wvalid & wready;
    assign wdata   = data;
    assign wstrb   = strb;
    assign bready  = state == W_RESP;

endmodule

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI3 master port between I-cache reads, D-cache reads
// and D-cache write-backs.
// Ports: clk/rstn (sync, active-low); i_r_* and d_r_* read request/return sets;
// ret_data shared read data; d_w_* write request/beat/finish set; AXI AR, R, AW, W, B.
// Reads are round-robin with one transaction outstanding; writes run in axi_wr_seq
// independently. A D-cache read to the line being written back waits for the write.
module cache_axi_arbiter
    import cache_axi_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 32,
    parameter int         LINE_OFF = LINE_OFF_DEF,
    parameter logic [3:0] ID_I     = 4'd0,
    parameter logic [3:0] ID_D     = 4'd1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_r_req,
    input  logic [ADDR_W-1:0] i_r_addr,
    input  logic [7:0]        i_r_length,
    input  logic [2:0]        i_r_size,
    output logic              i_r_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    input  logic              i_ret_ready,
    input  logic              d_r_req,
    input  logic [ADDR_W-1:0] d_r_addr,
    input  logic [7:0]        d_r_length,
    input  logic [2:0]        d_r_size,
    output logic              d_r_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    input  logic              d_ret_ready,
    output logic [DATA_W-1:0] ret_data,
    input  logic              d_w_req,
    input  logic [ADDR_W-1:0] d_w_addr,
    input  logic [7:0]        d_w_length,
    input  logic [2:0]        d_w_size,
    output logic              d_w_rdy,
    input  logic [DATA_W-1:0] d_w_data,
    input  logic [3:0]        d_w_strb,
    output logic              d_w_next,
    output logic              d_w_finish,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [3:0]        rid,
    input  logic              rlast,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready
);

    rd_state_t rs;
    owner_t    owner;
    owner_t    rr_last;
    logic      w_busy;
    logic      d_blocked;
    logic      d_elig;
    logic      pick_d;
    logic      in_data;
    logic      rid_unused;

    // rid carries no routing meaning: one read is outstanding, so the owner register decides
    assign rid_unused = ^rid;

    axi_wr_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
        .clk     (clk),
        .rstn    (rstn),
        .req     (d_w_req),
        .addr    (d_w_addr),
        .length  (d_w_length),
        .size    (d_w_size),
        .rdy     (d_w_rdy),
        .data    (d_w_data),
        .strb    (d_w_strb),
        .next    (d_w_next),
        .finish  (d_w_finish),
        .busy    (w_busy),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    assign d_blocked = w_busy && (d_r_addr[ADDR_W-1:LINE_OFF] == awaddr[ADDR_W-1:LINE_OFF]);
    assign d_elig    = d_r_req & ~d_blocked;
    // D wins only if I is absent or I was served last
    assign pick_d    = d_elig & (~i_r_req | (rr_last == OWN_I));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rs      <= R_IDLE;
            owner   <= OWN_I;
            rr_last <= OWN_D;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
        end else begin
            case (rs)
                R_IDLE: if (i_r_req | d_elig) begin
                    owner   <= pick_d ? OWN_D : OWN_I;
                    rr_last <= pick_d ? OWN_D : OWN_I;
                    araddr  <= pick_d ? d_r_addr : i_r_addr;
                    arlen   <= pick_d ? d_r_length : i_r_length;
                    arsize  <= pick_d ? d_r_size : i_r_size;
                    rs      <= R_ADDR;
                end
                R_ADDR: if (arready) rs <= R_DATA;
                R_DATA: if (rvalid && rready && rlast) rs <= R_IDLE;
                default: rs <= R_IDLE;
            endcase
        end
    end

    assign arvalid     = rs == R_ADDR;
    assign arid        = (owner == OWN_D) ? ID_D : ID_I;
    assign i_r_rdy     = arvalid & arready & (owner == OWN_I);
    assign d_r_rdy     = arvalid & arready & (owner == OWN_D);
    assign in_data     = rs == R_DATA;
    assign i_ret_valid = in_data & (owner == OWN_I) & rvalid;
    assign d_ret_valid = in_data & (owner == OWN_D) & rvalid;
    assign i_ret_last  = in_data & (owner == OWN_I) & rlast;
    assign d_ret_last  = in_data & (owner == OWN_D) & rlast;
    assign rready      = in_data & ((owner == OWN_D) ? d_ret_ready : i_ret_ready);
    assign ret_data    = rdata;

endmodule
